rld_scheduler: RTL

Round-robin scheduler sharing one run-length decoder between two token requesters. Each token is an 8-bit symbol plus a 4-bit repeat count. The block accepts one token at a time, drives the decoder's symbol/count inputs, and waits for the decoder's `ready` pulse. It then reports completion and moves to the next requester. It sits between the token sources and the decoder and also guards against a hung decoder with a watchdog.

---
 rtl/rld_pkg.sv | 29 ++
 rtl/rld_scheduler_rr_arb2.sv | 41 ++++
 rtl/rld_scheduler.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/rld_pkg.sv
// -----------------------------------------------------------------------------
// rld_pkg
// Shared types and widths for the run-length decoder scheduler and its
// arbiter. Imported by rld_scheduler and rr_arb2.
//   SYM_W             : token symbol width
//   CNT_W             : token repeat-count width
//   WD_W              : watchdog counter width
//   rld_sched_state_t : scheduler FSM states
//   rld_token_t       : {sym, cnt} token
// -----------------------------------------------------------------------------
package rld_pkg;

    localparam int SYM_W = 8;
    localparam int CNT_W = 4;
    localparam int WD_W  = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } rld_sched_state_t;

    typedef struct packed {
        logic [SYM_W-1:0] sym;
        logic [CNT_W-1:0] cnt;
    } rld_token_t;

endpackage

// File: rtl/rld_scheduler_rr_arb2.sv
// -----------------------------------------------------------------------------
// rr_arb2
// Two-way round-robin arbiter. A lone requester always wins; when both
// request, the requester named by the pointer wins. The pointer moves to the
// other requester whenever the current grant is accepted.
// Ports:
//   i_clk    : clock, rising edge
//   i_rst_n  : asynchronous active-low reset (pointer -> 0)
//   i_valid  : request vector {req1, req0}
//   i_accept : grant taken this cycle, advance the pointer
//   o_grant  : index of the winning requester (meaningful when any i_valid)
// -----------------------------------------------------------------------------
module rr_arb2 (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [1:0] i_valid,
    input  logic       i_accept,
    output logic       o_grant
);

    logic r_ptr;

    always_comb begin
        o_grant = 1'b0;
        case (i_valid)
            2'b10:   o_grant = 1'b1;
            2'b11:   o_grant = r_ptr;
            default: o_grant = 1'b0;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ptr <= 1'b0;
        end else if (i_accept) begin
            // Favour the requester that did not just win.
            r_ptr <= ~o_grant;
        end
    end

endmodule

// File: rtl/rld_scheduler.sv
// -----------------------------------------------------------------------------
// rld_scheduler
// Shares one run-length decoder between two token requesters. A token is
// accepted in IDLE, launched with a one-cycle start pulse, and completed when
// the decoder signals ready (or the watchdog expires). Completion is reported
// with a one-cycle done pulse carrying the requester id. Zero-count tokens
// bypass the decoder entirely.
// Optional feature macro: RLD_SCHED_STAT_EN adds per-requester completion
// counters (stat0/stat1, wrapping) and a watchdog event counter (stat_to,
// saturating).
// Parameters:
//   TIMEOUT     : WAIT cycles before the watchdog fires (2..255)
// Ports:
//   CLK, RST    : clock (rising edge), asynchronous active-low reset
//   reqN_valid  : requester N has a token; reqN_din / reqN_cin carry it
//   reqN_ready  : token from requester N accepted this cycle
//   dec_din/cin : token held towards the decoder from accept until done
//   dec_start   : one-cycle decoder start pulse
//   dec_ready   : decoder done pulse (honoured in WAIT only)
//   done        : one-cycle token-complete pulse, done_id names the requester
//   err_timeout : sticky watchdog flag
//   busy        : scheduler not in IDLE
//   stat0/stat1/stat_to : statistics (RLD_SCHED_STAT_EN only)
// -----------------------------------------------------------------------------
module rld_scheduler
    import rld_pkg::*;
#(
    parameter int TIMEOUT = 64
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             req0_valid,
    input  logic [SYM_W-1:0] req0_din,
    input  logic [CNT_W-1:0] req0_cin,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [SYM_W-1:0] req1_din,
    input  logic [CNT_W-1:0] req1_cin,
    output logic             req1_ready,
    output logic [SYM_W-1:0] dec_din,
    output logic [CNT_W-1:0] dec_cin,
    output logic             dec_start,
    input  logic             dec_ready,
    output logic             done,
    output logic             done_id,
    output logic             err_timeout,
    output logic             busy
`ifdef RLD_SCHED_STAT_EN
    ,
    output logic [15:0]      stat0,
    output logic [15:0]      stat1,
    output logic [7:0]       stat_to
`endif
);

    rld_sched_state_t r_state;
    rld_sched_state_t w_state_nxt;

    rld_token_t       r_tok;
    rld_token_t       w_tok;
    logic             r_done_id;
    logic             r_err;
    logic [WD_W-1:0]  r_wdog;
    logic [WD_W-1:0]  w_wdog_inc;
    logic             w_grant;
    logic             w_accept;
    logic             w_timeout;
    logic             w_idle;

    rr_arb2 u_arb (
        .i_clk    (CLK),
        .i_rst_n  (RST),
        .i_valid  ({req1_valid, req0_valid}),
        .i_accept (w_accept),
        .o_grant  (w_grant)
    );

    assign w_idle     = (r_state == IDLE);
    assign req0_ready = w_idle && req0_valid && !w_grant;
    assign req1_ready = w_idle && req1_valid &&  w_grant;
    assign w_accept   = req0_ready || req1_ready;

    always_comb begin
        w_tok = '{sym: req0_din, cnt: req0_cin};
        if (w_grant) begin
            w_tok = '{sym: req1_din, cnt: req1_cin};
        end
    end

    // Saturating increment; the watchdog only advances in WAIT without ready.
    assign w_wdog_inc = (r_wdog == '1) ? r_wdog : r_wdog + 1'b1;
    assign w_timeout  = (r_state == WAIT) && !dec_ready &&
                        (w_wdog_inc == WD_W'(TIMEOUT));

    always_comb begin
        w_state_nxt = r_state;
        dec_start   = 1'b0;
        done        = 1'b0;
        busy        = 1'b1;
        case (r_state)
            IDLE: begin
                busy = 1'b0;
                if (w_accept) begin
                    // Zero-count tokens never touch the decoder.
                    w_state_nxt = (w_tok.cnt == '0) ? DONE : ISSUE;
                end
            end
            ISSUE: begin
                dec_start   = 1'b1;
                w_state_nxt = WAIT;
            end
            WAIT: begin
                // A ready on the last allowed cycle beats the watchdog.
                if (dec_ready || w_timeout) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                done        = 1'b1;
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state   <= IDLE;
            r_tok     <= '0;
            r_done_id <= 1'b0;
            r_err     <= 1'b0;
            r_wdog    <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_tok     <= w_tok;
                r_done_id <= w_grant;
            end
            if (r_state == ISSUE) begin
                r_wdog <= '0;
            end else if ((r_state == WAIT) && !dec_ready) begin
                r_wdog <= w_wdog_inc;
            end
            if (w_timeout) begin
                r_err <= 1'b1;
            end
        end
    end

    assign dec_din     = r_tok.sym;
    assign dec_cin     = r_tok.cnt;
    assign done_id     = r_done_id;
    assign err_timeout = r_err;

`ifdef RLD_SCHED_STAT_EN
    logic [15:0] r_stat0;
    logic [15:0] r_stat1;
    logic [7:0]  r_stat_to;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_stat0   <= '0;
            r_stat1   <= '0;
            r_stat_to <= '0;
        end else begin
            if (r_state == DONE) begin
                if (r_done_id) begin
                    r_stat1 <= r_stat1 + 16'd1;
                end else begin
                    r_stat0 <= r_stat0 + 16'd1;
                end
            end
            if (w_timeout && (r_stat_to != 8'hFF)) begin
                r_stat_to <= r_stat_to + 8'd1;
            end
        end
    end

    assign stat0   = r_stat0;
    assign stat1   = r_stat1;
    assign stat_to = r_stat_to;
`endif

endmodule
